// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: FSM states, funct3 encodings, special-case results.
// Used by the multiply/divide unit and by the decode stage for M-extension decode.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_Q    = 32'h8000_0000;
  localparam logic [31:0] REM_OVF_R    = 32'h0000_0000;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic rs1_signed(input logic [2:0] f3);
    case (f3)
      MULH_F3, MULHSU_F3, DIV_F3, REM_F3: rs1_signed = 1'b1;
      default:                            rs1_signed = 1'b0;
    endcase
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    case (f3)
      MULH_F3, DIV_F3, REM_F3: rs2_signed = 1'b1;
      default:                 rs2_signed = 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [2:0] f3);
    is_div = f3[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_e.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on magnitudes, one bit per cycle, sharing a 64-bit shift register and counter.
module muldiv_unit_e
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            startE,
  input  logic            flushE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  localparam int            CW       = $clog2(ITERS);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [2*XLEN-1:0]   acc, acc_nxt;
  logic [XLEN-1:0]     opb, opb_nxt;
  logic [2:0]          f3, f3_nxt;
  logic                neg_res, neg_res_nxt;
  logic                neg_rem, neg_rem_nxt;
  logic [XLEN-1:0]     result_nxt;
  logic                result_we;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                accept, div_zero, div_ovf;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ok;
  logic [2*XLEN-1:0]   mul_step, div_step, step, prod_s;
  logic [XLEN-1:0]     quot, rem, final_res;

  // Operand conditioning in the start cycle.
  always_comb begin
    a_neg    = rs1_signed(funct3E) & srcAE[XLEN-1];
    b_neg    = rs2_signed(funct3E) & srcBE[XLEN-1];
    a_mag    = a_neg ? -srcAE : srcAE;
    b_mag    = b_neg ? -srcBE : srcBE;
    accept   = (state == IDLE) && startE && !flushE;
    div_zero = is_div(funct3E) && (srcBE == '0);
    div_ovf  = is_div(funct3E) && !funct3E[0] &&
               (srcAE == OVF_DIVIDEND) && (srcBE == {XLEN{1'b1}});
  end

  // One iteration of each datapath. Multiply keeps the multiplier in the low
  // half and shifts right; divide keeps the remainder high, quotient low.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_step  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ok    = !div_diff[XLEN];
    div_step  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 acc[XLEN-2:0], div_ok};
    step      = is_div(f3) ? div_step : mul_step;
  end

  // Sign fix applied to the value produced by the last iteration.
  always_comb begin
    prod_s = neg_res ? -step : step;
    quot   = step[XLEN-1:0];
    rem    = step[2*XLEN-1:XLEN];
    case (f3)
      MUL_F3:                      final_res = prod_s[XLEN-1:0];
      MULH_F3, MULHSU_F3, MULHU_F3: final_res = prod_s[2*XLEN-1:XLEN];
      DIV_F3, DIVU_F3:             final_res = neg_res ? -quot : quot;
      default:                     final_res = neg_rem ? -rem : rem;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path holds a
    // previous value combinationally, which would infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    opb_nxt     = opb;
    f3_nxt      = f3;
    neg_res_nxt = neg_res;
    neg_rem_nxt = neg_rem;
    result_nxt  = resultE;
    result_we   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          f3_nxt      = funct3E;
          neg_res_nxt = a_neg ^ b_neg;
          neg_rem_nxt = a_neg;
          opb_nxt     = b_mag;
          acc_nxt     = {{XLEN{1'b0}}, a_mag};
          cnt_nxt     = '0;
          if (div_zero) begin
            result_nxt = funct3E[1] ? srcAE : DIV_ZERO_Q;
            result_we  = 1'b1;
            state_nxt  = DONE;
          end else if (div_ovf) begin
            result_nxt = funct3E[1] ? REM_OVF_R : DIV_OVF_Q;
            result_we  = 1'b1;
            state_nxt  = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        acc_nxt = step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          result_nxt = final_res;
          result_we  = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A killed instruction leaves no trace on the result and frees the unit.
    if (flushE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      result_we = 1'b0;
    end
  end

  // NOTE: datapath registers are reset as well as the FSM so an abandoned
  // operation never leaks stale operands or a stale result after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      f3      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      resultE <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      opb     <= opb_nxt;
      f3      <= f3_nxt;
      neg_res <= neg_res_nxt;
      neg_rem <= neg_rem_nxt;
      if (result_we) resultE <= result_nxt;
    end
  end

  // Stall request drops with reset so the pipeline is released immediately.
  assign busyE = reset_n && (accept || (state == CALC));
  assign doneE = (state == DONE) && !flushE;

endmodule

// File: tb/tb_muldiv_unit_e.sv
// Scoreboard bench for muldiv_unit_e: directed ops push expected result and
// completion cycle; a forked monitor checks every doneE against the queue.
module tb_muldiv_unit_e;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        startE, flushE;
  logic [2:0]  funct3E;
  logic [31:0] srcAE, srcBE;
  logic        busyE, doneE;
  logic [31:0] resultE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  muldiv_unit_e #(.XLEN(32), .ITERS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .startE  (startE),
    .flushE  (flushE),
    .funct3E (funct3E),
    .srcAE   (srcAE),
    .srcBE   (srcBE),
    .busyE   (busyE),
    .doneE   (doneE),
    .resultE (resultE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one op in the current cycle and follow its busy window.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    int   busy_cnt;
    e.res = exp;
    e.cyc = cyc + lat;
    e.name = name;
    exp_q.push_back(e);
    funct3E = f3;
    srcAE   = a;
    srcBE   = b;
    startE  = 1'b1;
    busy_cnt = 0;
    @(negedge clk);
    if (busyE) busy_cnt++;
    @(posedge clk); #1;
    startE = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busyE) break;
      busy_cnt++;
    end
    check({name, "_busy_cycles"}, busy_cnt, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    startE  = 1'b0;
    flushE  = 1'b0;
    funct3E = '0;
    srcAE   = '0;
    srcBE   = '0;

    fork
      forever begin
        @(negedge clk);
        if (reset_n && doneE) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_result"}, resultE, e.res);
            check({e.name, "_done_cycle"}, cyc, e.cyc);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busyE}, 32'd0);
    check("reset_done", {31'd0, doneE}, 32'd0);
    check("reset_result", resultE, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul",     MUL_F3,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu",   MULHU_F3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",    MULH_F3,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("div",     DIV_F3,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",     REM_F3,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",    DIVU_F3,   32'd100,       32'd7,         32'd14,        33);
    run_op("div_ovf", DIV_F3,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", REM_F3,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_z",  DIVU_F3,   32'h1234,      32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_z",  REMU_F3,   32'h1234,      32'd0,         32'h0000_1234, 1);

    // Start together with flush must not be accepted.
    funct3E = MUL_F3; srcAE = 32'd9; srcBE = 32'd9;
    startE = 1'b1; flushE = 1'b1;
    #1;
    check("start_flush_busy", {31'd0, busyE}, 32'd0);
    @(posedge clk); #1;
    startE = 1'b0; flushE = 1'b0;
    check("start_flush_idle_busy", {31'd0, busyE}, 32'd0);
    @(posedge clk); #1;

    // Flush a DIV in cycle 10; unit is free in cycle 11 and result is held.
    funct3E = DIV_F3; srcAE = 32'd100; srcBE = 32'd7;
    startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0;
    check("flush_busy_low", {31'd0, busyE}, 32'd0);
    check("flush_no_done", {31'd0, doneE}, 32'd0);
    check("flush_result_held", resultE, 32'h0000_1234);
    run_op("mul_after_flush", MUL_F3, 32'd3, 32'd4, 32'd12, 33);

    // Reset asserted in cycle 5 of a MUL clears outputs at once.
    funct3E = MUL_F3; srcAE = 32'd5; srcBE = 32'd6;
    startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", {31'd0, busyE}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busyE}, 32'd0);
    check("async_reset_done", {31'd0, doneE}, 32'd0);
    check("async_reset_result", resultE, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    run_op("mulhsu_after_reset", MULHSU_F3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit_e.md
# muldiv_unit_e

Iterative RV32M multiply/divide unit in the execute stage. Consumes the operands, `funct3`, and M-extension valid flag coming out of the decode/execute pipeline register. Raises a stall request that holds the front of the pipeline while it iterates, then presents a single-cycle result for the EX result mux. Sits beside the ALU; the hazard logic ORs `busyE` into the F/D/E stall enables.

## Interface

Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.
- `ITERS`, 32: iterations per operation; must equal `XLEN`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous assert, active-low.
- `startE`, in, 1: valid M-extension instruction present in EX this cycle.
- `flushE`, in, 1: kill the EX instruction; aborts any operation in progress.
- `funct3E`, in, 3: M opcode. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcAE`, in, XLEN: rs1 operand, already forwarded.
- `srcBE`, in, XLEN: rs2 operand, already forwarded.
- `busyE`, out, 1: stall request for the IF, ID and EX pipeline registers.
- `doneE`, out, 1: `resultE` valid this cycle; EX result mux selects it.
- `resultE`, out, XLEN: operation result; held until the next completion.

## Operation

States: IDLE, CALC, DONE.

- **IDLE**
  - `startE` && !`flushE` latches `funct3E` and operands.
  - Operands are converted to magnitudes.
    - rs1 is signed for MULH, MULHSU, DIV and REM.
    - rs2 is signed for MULH, DIV and REM.
  - Sign flags are recorded.
  - Next state:
    - Special case → DONE.
    - Otherwise → CALC with iteration counter = 0.
- **CALC**
  - Multiply: shift-add, one multiplier bit per cycle into a 64-bit product accumulator.
  - Divide: restoring, one quotient bit per cycle. Uses a 33-bit partial remainder and a 32-bit quotient shift register.
  - Counter increments each cycle. At counter == ITERS-1, apply the final sign fix and go to DONE.
- **DONE**
  - `doneE`=1 for exactly one cycle, then IDLE.
  - `startE` is ignored while in DONE; the issuing instruction is leaving EX that cycle.
- **Result selection**
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits.
  - Product is negated (two's complement, 64-bit) when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of rs1.
- **Special cases** (resolved in the start cycle, no CALC)
  - Divisor 0:
    - DIV/DIVU → 0xFFFFFFFF.
    - REM/REMU → rs1.
  - Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF:
    - DIV → 0x80000000.
    - REM → 0.
- **`busyE`** (combinational) = (IDLE && `startE` && !`flushE`) || CALC.
- **`flushE`** in any state: next state IDLE, `doneE` suppressed, `resultE` unchanged.
  - `flushE` together with `startE` in IDLE: start is not accepted.
- **Reset**
  - State IDLE, counter 0, accumulators 0.
  - `resultE`=0, `doneE`=0, `busyE`=0.
  - Reset mid-operation abandons it; no `doneE` is generated.

## Timing

- Start cycle is cycle 0.
- Normal operation:
  - `busyE` high in cycles 0..32.
  - `doneE` and `resultE` valid in cycle 33.
  - EX advances at the end of cycle 33.
- Special case:
  - `busyE` high in cycle 0 only.
  - `doneE` in cycle 1.
- Back-to-back M ops: the next `startE` can be accepted in cycle 34, once the state is IDLE again.
- Flush in cycle k during CALC:
  - IDLE in cycle k+1.
  - `busyE` low from k+1.
- `resultE` registered; `doneE` registered (decoded from the DONE state).

## Structure

- `muldiv_pkg` holds:
  - The state enum (IDLE/CALC/DONE).
  - The `funct3` encoding constants (MUL_F3 … REMU_F3).
  - The overflow/div-by-zero result constants.
- The decode stage shares `muldiv_pkg` for its M-extension decode.
- Single module; no sub-module. The multiply and divide datapaths share the 64-bit shift register and the counter.

## Test plan

- **MUL.** MUL 7 × 0xFFFFFFFD (−3) → `busyE` cycles 0..32, `doneE` cycle 33, `resultE`=0xFFFFFFEB.
- **MULHU / MULH.**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH on the same operands → 0x00000000.
- **DIV / REM signed.**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM on the same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
- **Special cases.**
  - DIVU 0x1234 / 0 → 0xFFFFFFFF, `doneE` cycle 1.
  - REMU 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- **Flush.**
  - `flushE` at cycle 10 of a DIV → `busyE` low at cycle 11, no `doneE`, `resultE` unchanged.
  - A new MUL started at cycle 11 completes at cycle 44.
- **Reset.**
  - `reset_n` low at cycle 5 of a MUL → all outputs 0 immediately (asynchronous).
  - After release, the unit is IDLE and accepts a start on the first clock.
